// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITER  = 32;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    function automatic logic op_is_mul(op_e o);
        return (o == MULT) || (o == MULTU);
    endfunction

    function automatic logic op_is_signed(op_e o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// One adder and one {rh,rl} shift register serve both datapaths.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int LENGTH = MULDIV_WIDTH,
    parameter int ITER   = LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    input  logic [1:0]        op,
    input  logic              start,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [LENGTH-1:0] wdata,
    output logic [LENGTH-1:0] hi,
    output logic [LENGTH-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e            state;
    op_e               op_q;
    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] ma;
    logic [LENGTH-1:0] mb;
    logic [LENGTH-1:0] araw;
    logic [LENGTH-1:0] rh;
    logic [LENGTH-1:0] rl;
    logic [LENGTH-1:0] hi_q;
    logic [LENGTH-1:0] lo_q;
    logic              neg_p;
    logic              neg_r;
    logic              dz;
    logic              done_q;

    op_e               op_in;
    logic              is_mul;
    logic              sa;
    logic              sb;
    logic [LENGTH-1:0] mag_a;
    logic [LENGTH-1:0] mag_b;
    logic [LENGTH:0]   x;
    logic [LENGTH:0]   y;
    logic [LENGTH:0]   sum;
    logic [LENGTH-1:0] nrh;
    logic [LENGTH-1:0] nrl;
    logic [2*LENGTH-1:0] prod;
    logic [2*LENGTH-1:0] prod_fix;
    logic [LENGTH-1:0] q_fix;
    logic [LENGTH-1:0] r_fix;
    logic [LENGTH-1:0] res_hi;
    logic [LENGTH-1:0] res_lo;

    assign op_in  = op_e'(op);
    assign is_mul = op_is_mul(op_q);
    assign sa     = op_is_signed(op_in) & a[LENGTH-1];
    assign sb     = op_is_signed(op_in) & b[LENGTH-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;

    // Multiply adds the multiplicand; divide subtracts the divisor (cin=1).
    always_comb begin
        x   = '0;
        y   = '0;
        nrh = rh;
        nrl = rl;
        if (is_mul) begin
            x = {1'b0, rh};
            y = rl[0] ? {1'b0, ma} : '0;
        end else begin
            x = {rh, rl[LENGTH-1]};
            y = ~{1'b0, mb};
        end
        sum = x + y + {{LENGTH{1'b0}}, ~is_mul};
        if (is_mul) begin
            nrh = sum[LENGTH:1];
            nrl = {sum[0], rl[LENGTH-1:1]};
        end else begin
            // sum[LENGTH] set means the trial subtraction borrowed
            nrh = sum[LENGTH] ? x[LENGTH-1:0] : sum[LENGTH-1:0];
            nrl = {rl[LENGTH-2:0], ~sum[LENGTH]};
        end
    end

    always_comb begin
        prod     = {rh, rl};
        prod_fix = neg_p ? -prod : prod;
        q_fix    = neg_p ? -rl : rl;
        r_fix    = neg_r ? -rh : rh;
        res_hi   = r_fix;
        res_lo   = q_fix;
        if (is_mul) begin
            res_hi = prod_fix[2*LENGTH-1:LENGTH];
            res_lo = prod_fix[LENGTH-1:0];
        end else if (dz) begin
            res_hi = araw;
            res_lo = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= MULT;
            cnt    <= '0;
            ma     <= '0;
            mb     <= '0;
            araw   <= '0;
            rh     <= '0;
            rl     <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        op_q  <= op_in;
                        cnt   <= '0;
                        ma    <= mag_a;
                        mb    <= mag_b;
                        araw  <= a;
                        rh    <= '0;
                        rl    <= op_is_mul(op_in) ? mag_b : mag_a;
                        neg_p <= sa ^ sb;
                        neg_r <= sa;
                        dz    <= (b == '0);
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        rh <= nrh;
                        rl <= nrl;
                        if (cnt == CW'(ITER - 1)) begin
                            state <= FIXUP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state != IDLE);
    assign done = done_q;

endmodule
